alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the combinational datapath ALU.
- Registers its result and adds SUB, logic ops, shifts, condition flags and an illegal-op error.
- Adds a full-width iterative signed multiply; the combinational ALU only multiplies the low halves.
- Sits between operand fetch and register write-back in the simpleComputer datapath. Multi-cycle ops stall the producer through valid/ready backpressure.

Parameters:
- DATA_WIDTH, 32: operand and result width; must be even and ≥ 4.
- OP_WIDTH, 4: opcode width; must be ≥ 4.
- SH_WIDTH, $clog2(DATA_WIDTH): number of in2 LSBs used as the shift amount; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an op this cycle.
- op  in  OP_WIDTH  operation code.
- in1  in  DATA_WIDTH  signed operand 1.
- in2  in  DATA_WIDTH  signed operand 2.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- out_alu  out  DATA_WIDTH  signed result.
- flag_z  out  1  out_alu == 0.
- flag_n  out  1  out_alu MSB.
- flag_v  out  1  signed overflow, ADD/SUB only.
- err  out  1  op was illegal.

Behaviour:
- Reset values: all outputs and internal registers = 0; state = IDLE; in_ready = 1 once rst deasserts.
- Opcodes:
  - 0: in2; 1: in1; 2: ADD in1+in2; 3: MUL, low DATA_WIDTH bits of in1*in2.
  - 4: EQ, 1 if in1==in2; 5: LT, 1 if signed in1<in2; 6: NOT, ~in2; 7: SUB in1-in2.
  - 8: AND; 9: OR; 10: XOR.
  - 11: SHL, in1 << in2[SH_WIDTH-1:0]; 12: SRA, arithmetic in1 >>> in2[SH_WIDTH-1:0]; upper in2 bits ignored.
  - 13..2^OP_WIDTH-1: illegal → out_alu=0, err=1, flag_z=1.
- EQ/LT results are zero-extended to DATA_WIDTH. ADD/SUB wrap modulo 2^DATA_WIDTH.
- flag_v is set when:
  - ADD: in1 and in2 have equal signs and the result sign differs.
  - SUB: in1 and in2 have different signs and the result sign differs from in1.
  - flag_v = 0 for all other ops.
- States: IDLE, BUSY (multiply in progress), HOLD (result presented).
- in_ready = (state==IDLE) || (state==HOLD && out_ready). in_ready is 0 in BUSY.
- An op is accepted on a rising edge with in_valid && in_ready. op, in1 and in2 are sampled only on that edge.
- Non-MUL accept: result and flags registered on the accept edge → HOLD. out_valid rises the cycle after accept (latency 1).
- MUL accept:
  - Latch the multiplicand (in1), the multiplier (in2), accumulator=0 and count=0; enter BUSY.
  - Each BUSY edge: if multiplier LSB=1, accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
  - After DATA_WIDTH BUSY edges, write the accumulator to out_alu → HOLD.
  - out_valid rises DATA_WIDTH+1 cycles after accept.
  - Unsigned shift-add gives the correct two's-complement low product for signed operands.
- HOLD:
  - out_valid=1. out_alu and flags stay stable until out_valid && out_ready.
  - On out_ready with no new accept → IDLE, out_valid=0; out_alu and flags keep their last values.
  - On out_ready with a simultaneous accept: a non-MUL op stays in HOLD with the new result (back-to-back throughput 1 per cycle); a MUL op → BUSY with out_valid=0.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored; the producer must hold its values.
- rst asserted in any state, including mid-multiply: immediate return to IDLE, all outputs 0, the partial product is discarded.
- MUL sets flag_v=0 and err=0; flag_z and flag_n follow the final product.

Test Plan (DATA_WIDTH=32):
- Reset, then ADD in1=0x7FFFFFFF, in2=1, out_ready=1 → out_valid 1 cycle later; out_alu=0x80000000, flag_v=1, flag_n=1, flag_z=0.
- SUB 5−5, then 13 back-to-back non-MUL ops with out_ready=1 → first out_alu=0, flag_z=1; in_ready stays 1 and one result appears per cycle.
- MUL in1=−3, in2=100000 → in_ready=0 for 32 cycles; out_valid at cycle 33; out_alu=0xFFFB6C20 (−300000), flag_n=1.
- SRA in1=0x80000000, in2=0x21, then SHL in1=1, in2=31 → out_alu=0xC0000000, then 0x80000000.
- op=14 → out_alu=0, err=1, flag_z=1. Then LT in1=−1, in2=0 → out_alu=1, err=0.
- Backpressure: hold out_ready=0 for 5 cycles after an EQ result → out_alu stable and in_ready=0 throughout. Separately, assert rst on the 10th BUSY cycle of a MUL → all outputs 0 and in_ready=1 after release.

Source files
------------

// File: rtl/alu_pipe.sv
// Pipelined, handshaked ALU with registered result, condition flags and
// an iterative shift-add multiplier that stalls the producer while busy.
module alu_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH = 4,
    localparam int SH_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_alu,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  flag_v,
    output logic                  err
);

    localparam int MSB = DATA_WIDTH - 1;

    localparam logic [OP_WIDTH-1:0] OP_IN2 = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_IN1 = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_EQ  = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_LT  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_NOT = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_SHL = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_SRA = OP_WIDTH'(12);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [SH_WIDTH-1:0]   count;

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] res;
    logic [SH_WIDTH-1:0]   sh;
    logic                  ovf;
    logic                  ill;
    logic                  accept;
    logic                  is_mul;
    logic                  last;

    assign in_ready  = !rst && (state == IDLE || (state == HOLD && out_ready));
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op == OP_MUL);

    assign sum  = in1 + in2;
    assign diff = in1 - in2;
    assign sh   = in2[SH_WIDTH-1:0];

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign last     = (count == SH_WIDTH'(DATA_WIDTH - 1));

    always_comb begin
        res = '0;
        ovf = 1'b0;
        ill = 1'b0;
        case (op)
            OP_IN2: res = in2;
            OP_IN1: res = in1;
            OP_ADD: begin
                res = sum;
                ovf = (in1[MSB] == in2[MSB]) && (sum[MSB] != in1[MSB]);
            end
            OP_MUL: res = '0;
            OP_EQ:  res = DATA_WIDTH'(in1 == in2);
            OP_LT:  res = DATA_WIDTH'($signed(in1) < $signed(in2));
            OP_NOT: res = ~in2;
            OP_SUB: begin
                res = diff;
                ovf = (in1[MSB] != in2[MSB]) && (diff[MSB] != in1[MSB]);
            end
            OP_AND: res = in1 & in2;
            OP_OR:  res = in1 | in2;
            OP_XOR: res = in1 ^ in2;
            OP_SHL: res = in1 << sh;
            OP_SRA: res = $signed(in1) >>> sh;
            default: ill = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = is_mul ? BUSY : HOLD;
            end
            BUSY: begin
                if (last) state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    if (accept) state_next = is_mul ? BUSY : HOLD;
                    else state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end

    // Multiplier operands are only loaded on a MUL accept; result
    // registers keep their last value until the next completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_alu <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_v  <= 1'b0;
            err     <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= in1;
                mplier <= in2;
                acc    <= '0;
                count  <= '0;
            end else begin
                out_alu <= res;
                flag_z  <= (res == '0);
                flag_n  <= res[MSB];
                flag_v  <= ovf;
                err     <= ill;
            end
        end else if (state == BUSY) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + SH_WIDTH'(1);
            if (last) begin
                out_alu <= acc_next;
                flag_z  <= (acc_next == '0);
                flag_n  <= acc_next[MSB];
                flag_v  <= 1'b0;
                err     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: literal checks on key vectors plus a
// queue-based reference model compared on every consumed result.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu;
    logic        flag_z;
    logic        flag_n;
    logic        flag_v;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        n;
        logic        v;
        logic        e;
    } exp_t;

    exp_t q[$];

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic [3:0]  bo[14] = '{4'd7, 4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6,
                            4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
    logic [31:0] ba[14] = '{32'd5, 32'h1111_1111, 32'hDEAD_BEEF,
                            32'h8000_0000, 32'd42, 32'h8000_0000, 32'h0,
                            32'h8000_0000, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                            32'hF0F0_F0F0, 32'h0000_0003, 32'hF000_0000,
                            32'h1};
    logic [31:0] bb[14] = '{32'd5, 32'h2222_2222, 32'h0, 32'h8000_0000,
                            32'd42, 32'h1, 32'h0F0F_0F0F, 32'h1,
                            32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00,
                            32'h4, 32'hFFFF_FFE4, 32'h7};

    alu_pipe dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .in1(in1),
        .in2(in2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_alu(out_alu),
        .flag_z(flag_z),
        .flag_n(flag_n),
        .flag_v(flag_v),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        longint sa;
        longint sb;
        longint w;
        exp_t e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        w = 0;
        e = '0;
        case (o)
            4'd0: e.r = b;
            4'd1: e.r = a;
            4'd2: begin
                w = sa + sb;
                e.r = w[31:0];
                e.v = (w > MAXV) || (w < MINV);
            end
            4'd3: begin
                w = sa * sb;
                e.r = w[31:0];
            end
            4'd4: e.r = (a == b) ? 32'd1 : 32'd0;
            4'd5: e.r = (sa < sb) ? 32'd1 : 32'd0;
            4'd6: e.r = ~b;
            4'd7: begin
                w = sa - sb;
                e.r = w[31:0];
                e.v = (w > MAXV) || (w < MINV);
            end
            4'd8: e.r = a & b;
            4'd9: e.r = a | b;
            4'd10: e.r = a ^ b;
            4'd11: e.r = a << b[4:0];
            4'd12: begin
                w = sa >>> b[4:0];
                e.r = w[31:0];
            end
            default: e.e = 1'b1;
        endcase
        e.z = (e.r == 32'd0);
        e.n = e.r[31];
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after accept.
    task automatic send(input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b);
        bit done;
        done = 1'b0;
        op = o;
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            #1;
            if (in_ready) begin
                q.push_back(model(o, a, b));
                done = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: op %0d never accepted", o);
        end
    endtask

    // Scoreboard: compare every result the consumer takes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %h expected none",
                             out_alu);
                end else begin
                    e = q.pop_front();
                    chk("sb_out_alu", out_alu, e.r);
                    chk("sb_flags_zvne", {28'd0, flag_z, flag_n, flag_v, err},
                        {28'd0, e.z, e.n, e.v, e.e});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        in1 = '0;
        in2 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outputs", {out_valid, in_ready, flag_z, flag_n, flag_v, err},
            32'd0);
        chk("rst_out_alu", out_alu, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        out_ready = 1'b1;
        send(4'd2, 32'h7FFF_FFFF, 32'd1);
        #1;
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_out_alu", out_alu, 32'h8000_0000);
        chk("add_flags_vnz", {29'd0, flag_v, flag_n, flag_z}, 32'b110);
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            op = bo[i];
            in1 = ba[i];
            in2 = bb[i];
            in_valid = 1'b1;
            #1;
            chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
            if (i > 0) chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
            if (i == 1) begin
                chk("sub_zero_out_alu", out_alu, 32'd0);
                chk("sub_zero_flag_z", {31'd0, flag_z}, 32'd1);
            end
            q.push_back(model(bo[i], ba[i], bb[i]));
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);

        send(4'd3, 32'hFFFF_FFFD, 32'd100000);
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("mul_busy_ready_valid", {30'd0, in_ready, out_valid}, 32'd0);
            @(negedge clk);
        end
        #1;
        chk("mul_valid", {31'd0, out_valid}, 32'd1);
        chk("mul_out_alu", out_alu, 32'hFFFB_6C20);
        chk("mul_flag_n", {31'd0, flag_n}, 32'd1);
        @(negedge clk);

        send(4'd12, 32'h8000_0000, 32'h21);
        #1;
        chk("sra_out_alu", out_alu, 32'hC000_0000);
        @(negedge clk);
        send(4'd11, 32'd1, 32'd31);
        #1;
        chk("shl_out_alu", out_alu, 32'h8000_0000);
        @(negedge clk);

        send(4'd14, 32'd5, 32'd6);
        #1;
        chk("ill_out_alu", out_alu, 32'd0);
        chk("ill_err_z", {30'd0, err, flag_z}, 32'b11);
        @(negedge clk);
        send(4'd5, 32'hFFFF_FFFF, 32'd0);
        #1;
        chk("lt_out_alu", out_alu, 32'd1);
        chk("lt_err", {31'd0, err}, 32'd0);
        @(negedge clk);

        out_ready = 1'b0;
        send(4'd4, 32'd9, 32'd9);
        op = 4'd2;
        in1 = 32'd3;
        in2 = 32'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_out_alu", out_alu, 32'd1);
            chk("bp_ready_valid", {30'd0, in_ready, out_valid}, 32'b01);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        q.push_back(model(4'd2, 32'd3, 32'd4));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_next_out_alu", out_alu, 32'd7);
        @(negedge clk);

        send(4'd3, 32'd12345, 32'd678);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        q.delete();
        #1;
        chk("midmul_rst_outputs",
            {out_valid, in_ready, flag_z, flag_n, flag_v, err}, 32'd0);
        chk("midmul_rst_out_alu", out_alu, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midmul_release", {30'd0, in_ready, out_valid}, 32'b10);
        @(negedge clk);

        send(4'd3, 32'hFFFF_FFF9, 32'hFFFF_FFF7);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            #1;
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("mul2_valid", {31'd0, out_valid}, 32'd1);
        chk("mul2_out_alu", out_alu, 32'd63);
        @(negedge clk);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
